frame_swap_controller: RTL and testbench
========================================

# frame_swap_controller

Sequencer for the double-buffered display memory. Owns back-buffer port b and the frame_complete swap strobe. Arbitrates port b between a renderer request interface and an internal clear engine. Issues the buffer swap only at a display vertical-blank boundary, after the renderer has declared the frame finished.

## Interface
Parameters:
- WIDTH, 640, visible columns cleared and accepted (≤1024)
- HEIGHT, 480, visible rows cleared and accepted (≤512)
- CLEAR_ON_SWAP, 1, clear the new back buffer after every swap and after reset
- CLEAR_COLOR, '0, pixel_t value written by the clear engine

Ports:
- clock  in  1  system clock
- reset  in  1  asynchronous, active-high
- req_valid  in  1  renderer request valid
- req_write  in  1  1 = write, 0 = read
- req_x  in  10  column
- req_y  in  10  row
- req_data  in  pixel_t  write data
- req_ready  out  1  request accepted when valid && ready
- rsp_valid  out  1  read data valid, single-cycle pulse
- rsp_data  out  pixel_t  read data
- render_done  in  1  pulse, renderer finished current frame
- vblank_start  in  1  pulse, display entered vertical blank
- address_b_x  out  10  to buffer mux port b
- address_b_y  out  10  to buffer mux port b
- write_enable_b  out  1  to buffer mux
- write_data_b  out  pixel_t  to buffer mux
- data_b  in  pixel_t  from buffer mux, valid one cycle after address is presented
- frame_complete  out  1  swap strobe, single-cycle pulse
- frame_count  out  16  swaps issued, wraps at 65535→0
- busy  out  1  high in CLEAR, WAIT_VSYNC, SWAP

## Operation
State machine with states CLEAR, RENDER, WAIT_VSYNC, SWAP. Reset enters CLEAR if CLEAR_ON_SWAP=1, otherwise RENDER.

- **CLEAR**
  - Raster counter walks x 0..WIDTH-1 (inner) and y 0..HEIGHT-1.
  - Writes CLEAR_COLOR to one pixel per cycle.
  - req_ready=0.
  - The cycle after the last pixel (WIDTH-1, HEIGHT-1) is issued, the state moves to RENDER and the counters return to 0.
- **RENDER**
  - req_ready=1.
  - Accepted write: registered onto port b with write_enable_b=1 for exactly one cycle.
  - Accepted read: address registered with write_enable_b=0. The next cycle, rsp_valid=1 and rsp_data=data_b.
  - Out-of-range request (x≥WIDTH or y≥HEIGHT): still accepted. A write is suppressed (write_enable_b stays 0). A read returns rsp_data=CLEAR_COLOR, with the same latency as an in-range read.
  - render_done moves the state to WAIT_VSYNC. A request accepted in the same cycle completes normally.
- **WAIT_VSYNC**
  - req_ready=0.
  - vblank_start moves the state to SWAP.
  - render_done is ignored.
- **SWAP**
  - One cycle: frame_complete=1 and frame_count increments.
  - Next state is CLEAR if CLEAR_ON_SWAP=1, else RENDER.
- Ignored inputs:
  - render_done outside RENDER.
  - vblank_start outside WAIT_VSYNC. A vblank arriving during RENDER is not remembered.
- A pending read response is delivered even if the state leaves RENDER.
- Port b address outputs hold their last value when idle.
- Reset mid-operation:
  - Aborts any clear and drops any pending response.
  - No frame_complete is issued.
  - Restarts the clear from (0,0).

## Timing
- Reset values:
  - req_ready=0 (1 if CLEAR_ON_SWAP=0).
  - rsp_valid=0, rsp_data=0.
  - address_b_x=0, address_b_y=0.
  - write_enable_b=0, write_data_b=0.
  - frame_complete=0, frame_count=0.
  - busy=1 (0 if CLEAR_ON_SWAP=0).
- Write latency: accept at cycle N, so port b outputs are valid during cycle N+1 and memory updates at the end of N+1.
- Read latency: accept at N, address presented at N+1, rsp_valid at N+2.
- Throughput: one request per cycle, back-to-back.
- Clear duration: WIDTH×HEIGHT cycles, with the first write presented the cycle after entering CLEAR.
- frame_complete: asserted the cycle after vblank_start is sampled in WAIT_VSYNC.
- Clear after swap: the first clear write appears on port b the cycle after frame_complete, so it targets the new back buffer.
- All outputs are registered. There is no combinational path from inputs to outputs except req_ready, which is decoded from state.

## Structure
- Shared package display_pkg:
  - pixel_t.
  - BUF_X_BITS=10, BUF_Y_BITS=9.
  - fsc_state_t enum (CLEAR, RENDER, WAIT_VSYNC, SWAP).
- Sub-module raster_scanner:
  - x/y counter with WIDTH/HEIGHT parameters.
  - Inputs start and advance; outputs x, y, last.
  - Reusable by the video timing generator.

## Test plan
Use WIDTH=4, HEIGHT=2, CLEAR_COLOR=8'h00 unless stated.

- **Reset clear:** release reset → 8 consecutive writes (0,0),(1,0)..(3,1) with data 0. busy falls and req_ready rises the following cycle.
- **Write then read:** write (2,1)=8'hA5 accepted at N → write_enable_b=1 at N+1. Read (2,1) accepted at N+2 → rsp_valid=1, rsp_data=8'hA5 at N+4.
- **Out of range:** write (5,0) → write_enable_b never asserts. Read (0,3) → rsp_data=CLEAR_COLOR after 2 cycles.
- **Swap gating:** render_done, then vblank_start 10 cycles later → exactly one frame_complete pulse, 1 cycle after vblank. frame_count=1. 8 clear writes follow. A vblank_start pulsed before render_done produces no swap.
- **Reset mid-clear:** assert reset after 3 clear writes → after release, the clear restarts at (0,0) and frame_count=0.
- **CLEAR_ON_SWAP=0:** after frame_complete, req_ready=1 on the next cycle with no port-b writes.

Source files
------------

// File: rtl/display_pkg.sv
// display_pkg
// Shared types and sizing constants for the double-buffered display path.
//   pixel_t      : one pixel as stored in the frame buffers
//   BUF_X_BITS   : column counter width (up to 1024 columns)
//   BUF_Y_BITS   : row counter width (up to 512 rows)
//   fsc_state_t  : sequencer states of frame_swap_controller
package display_pkg;

  typedef logic [7:0] pixel_t;

  localparam int BUF_X_BITS = 10;
  localparam int BUF_Y_BITS = 9;

  typedef enum logic [1:0] {
    CLEAR      = 2'd0,
    RENDER     = 2'd1,
    WAIT_VSYNC = 2'd2,
    SWAP       = 2'd3
  } fsc_state_t;

endpackage

// File: rtl/raster_scanner.sv
// raster_scanner
// Raster-order x/y counter. x runs 0..WIDTH-1 and is the inner loop; y runs
// 0..HEIGHT-1. The position wraps back to (0,0) after the last pixel.
// Ports:
//   clock, reset : system clock, asynchronous active-high reset
//   start        : return the position to (0,0); overrides advance
//   advance      : step to the next raster position
//   x, y         : current raster position
//   last         : high while the position is (WIDTH-1, HEIGHT-1)
module raster_scanner
  import display_pkg::*;
#(
  parameter int WIDTH  = 640,
  parameter int HEIGHT = 480
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  advance,
  output logic [BUF_X_BITS-1:0] x,
  output logic [BUF_Y_BITS-1:0] y,
  output logic                  last
);

  localparam logic [BUF_X_BITS-1:0] X_MAX = BUF_X_BITS'(WIDTH - 1);
  localparam logic [BUF_Y_BITS-1:0] Y_MAX = BUF_Y_BITS'(HEIGHT - 1);

  logic [BUF_X_BITS-1:0] x_q, x_d;
  logic [BUF_Y_BITS-1:0] y_q, y_d;

  always_comb begin
    x_d = x_q;
    y_d = y_q;
    if (start) begin
      x_d = '0;
      y_d = '0;
    end else if (advance) begin
      if (x_q == X_MAX) begin
        x_d = '0;
        y_d = (y_q == Y_MAX) ? '0 : y_q + 1'b1;
      end else begin
        x_d = x_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      x_q <= '0;
      y_q <= '0;
    end else begin
      x_q <= x_d;
      y_q <= y_d;
    end
  end

  assign x    = x_q;
  assign y    = y_q;
  assign last = (x_q == X_MAX) && (y_q == Y_MAX);

endmodule

// File: rtl/frame_swap_controller.sv
// frame_swap_controller
// Owns back-buffer port b of the double-buffered display memory. Arbitrates
// port b between renderer requests and an internal clear engine, and issues
// the buffer swap strobe only at vertical blank after render_done.
// Ports:
//   clock, reset          : system clock, asynchronous active-high reset
//   req_*                 : renderer request (valid/ready handshake)
//   rsp_valid, rsp_data   : read response, one-cycle pulse
//   render_done           : renderer finished the current frame
//   vblank_start          : display entered vertical blank
//   address_b_*, write_*  : registered port b drive to the buffer mux
//   data_b                : port b read data from the buffer mux
//   frame_complete        : swap strobe, one-cycle pulse
//   frame_count           : number of swaps issued (wraps)
//   busy                  : high whenever renderer requests are not accepted
module frame_swap_controller
  import display_pkg::*;
#(
  parameter int     WIDTH         = 640,
  parameter int     HEIGHT        = 480,
  parameter bit     CLEAR_ON_SWAP = 1'b1,
  parameter pixel_t CLEAR_COLOR   = '0
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         req_valid,
  input  logic         req_write,
  input  logic [9:0]   req_x,
  input  logic [9:0]   req_y,
  input  pixel_t       req_data,
  output logic         req_ready,
  output logic         rsp_valid,
  output pixel_t       rsp_data,
  input  logic         render_done,
  input  logic         vblank_start,
  output logic [9:0]   address_b_x,
  output logic [9:0]   address_b_y,
  output logic         write_enable_b,
  output pixel_t       write_data_b,
  input  pixel_t       data_b,
  output logic         frame_complete,
  output logic [15:0]  frame_count,
  output logic         busy
);

  localparam fsc_state_t RESET_STATE = CLEAR_ON_SWAP ? CLEAR : RENDER;

  fsc_state_t  state_q, state_d;
  logic [9:0]  addr_x_q, addr_x_d;
  logic [9:0]  addr_y_q, addr_y_d;
  logic        we_q, we_d;
  pixel_t      wdata_q, wdata_d;
  logic        rd_pend_q, rd_pend_d;
  logic        rd_oor_q, rd_oor_d;
  logic        rsp_valid_q, rsp_valid_d;
  pixel_t      rsp_data_q, rsp_data_d;
  logic        frame_complete_q, frame_complete_d;
  logic [15:0] frame_count_q, frame_count_d;
  logic        busy_q, busy_d;

  logic                  accept;
  logic                  in_range;
  logic                  clear_issue;
  logic                  scan_start;
  logic [BUF_X_BITS-1:0] scan_x;
  logic [BUF_Y_BITS-1:0] scan_y;
  logic                  scan_last;

  assign accept   = (state_q == RENDER) && req_valid;
  assign in_range = ({1'b0, req_x} < 11'(WIDTH)) && ({1'b0, req_y} < 11'(HEIGHT));

  // The SWAP cycle already issues pixel (0,0) so the first clear write lands
  // on port b the cycle after frame_complete, i.e. on the new back buffer.
  assign clear_issue = (state_q == CLEAR) || (CLEAR_ON_SWAP && (state_q == SWAP));

  // Hold the scanner at the origin whenever no clear is in flight.
  assign scan_start = (state_q == RENDER) || (state_q == WAIT_VSYNC);

  raster_scanner #(
    .WIDTH  (WIDTH),
    .HEIGHT (HEIGHT)
  ) u_scanner (
    .clock   (clock),
    .reset   (reset),
    .start   (scan_start),
    .advance (clear_issue),
    .x       (scan_x),
    .y       (scan_y),
    .last    (scan_last)
  );

  always_comb begin
    state_d          = state_q;
    addr_x_d         = addr_x_q;
    addr_y_d         = addr_y_q;
    we_d             = 1'b0;
    wdata_d          = wdata_q;
    rd_pend_d        = 1'b0;
    rd_oor_d         = 1'b0;
    rsp_valid_d      = rd_pend_q;
    rsp_data_d       = rsp_data_q;
    frame_complete_d = 1'b0;
    frame_count_d    = frame_count_q;

    // A pending read completes regardless of the current state.
    if (rd_pend_q) begin
      rsp_data_d = rd_oor_q ? CLEAR_COLOR : data_b;
    end

    if (clear_issue) begin
      addr_x_d = scan_x;
      addr_y_d = {{(10 - BUF_Y_BITS){1'b0}}, scan_y};
      we_d     = 1'b1;
      wdata_d  = CLEAR_COLOR;
    end

    // Out-of-range requests never touch port b; reads answer CLEAR_COLOR.
    if (accept) begin
      rd_pend_d = !req_write;
      rd_oor_d  = !req_write && !in_range;
      if (in_range) begin
        addr_x_d = req_x;
        addr_y_d = req_y;
        we_d     = req_write;
        if (req_write) begin
          wdata_d = req_data;
        end
      end
    end

    case (state_q)
      CLEAR: begin
        if (scan_last) begin
          state_d = RENDER;
        end
      end
      RENDER: begin
        if (render_done) begin
          state_d = WAIT_VSYNC;
        end
      end
      WAIT_VSYNC: begin
        if (vblank_start) begin
          state_d          = SWAP;
          frame_complete_d = 1'b1;
          frame_count_d    = frame_count_q + 16'd1;
        end
      end
      SWAP: begin
        state_d = (CLEAR_ON_SWAP && !scan_last) ? CLEAR : RENDER;
      end
      default: begin
        state_d = RESET_STATE;
      end
    endcase

    busy_d = (state_d != RENDER);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q          <= RESET_STATE;
      addr_x_q         <= '0;
      addr_y_q         <= '0;
      we_q             <= 1'b0;
      wdata_q          <= '0;
      rd_pend_q        <= 1'b0;
      rd_oor_q         <= 1'b0;
      rsp_valid_q      <= 1'b0;
      rsp_data_q       <= '0;
      frame_complete_q <= 1'b0;
      frame_count_q    <= '0;
      busy_q           <= (RESET_STATE != RENDER);
    end else begin
      state_q          <= state_d;
      addr_x_q         <= addr_x_d;
      addr_y_q         <= addr_y_d;
      we_q             <= we_d;
      wdata_q          <= wdata_d;
      rd_pend_q        <= rd_pend_d;
      rd_oor_q         <= rd_oor_d;
      rsp_valid_q      <= rsp_valid_d;
      rsp_data_q       <= rsp_data_d;
      frame_complete_q <= frame_complete_d;
      frame_count_q    <= frame_count_d;
      busy_q           <= busy_d;
    end
  end

  assign req_ready      = (state_q == RENDER);
  assign rsp_valid      = rsp_valid_q;
  assign rsp_data       = rsp_data_q;
  assign address_b_x    = addr_x_q;
  assign address_b_y    = addr_y_q;
  assign write_enable_b = we_q;
  assign write_data_b   = wdata_q;
  assign frame_complete = frame_complete_q;
  assign frame_count    = frame_count_q;
  assign busy           = busy_q;

endmodule

// File: tb/tb_frame_swap_controller.sv
// tb_frame_swap_controller
// Directed bench for frame_swap_controller on a 4x2 frame. One instance
// clears on swap and talks to a small behavioural buffer; a second instance
// has clearing disabled.
module tb_frame_swap_controller;
  import display_pkg::*;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic        reset = 1'b1;
  logic        req_valid = 1'b0, req_write = 1'b0;
  logic [9:0]  req_x = '0, req_y = '0;
  pixel_t      req_data = '0;
  logic        req_ready, rsp_valid;
  pixel_t      rsp_data;
  logic        render_done = 1'b0, vblank_start = 1'b0;
  logic [9:0]  address_b_x, address_b_y;
  logic        write_enable_b;
  pixel_t      write_data_b, data_b;
  logic        frame_complete, busy;
  logic [15:0] frame_count;

  logic        reset_nc = 1'b1;
  logic        render_done_nc = 1'b0, vblank_start_nc = 1'b0;
  logic        req_ready_nc, rsp_valid_nc, write_enable_b_nc, frame_complete_nc, busy_nc;
  pixel_t      rsp_data_nc, write_data_b_nc;
  pixel_t      data_b_nc = '0;
  logic [9:0]  address_b_x_nc, address_b_y_nc;
  logic [15:0] frame_count_nc;

  int checks = 0;
  int errors = 0;

  pixel_t mem [0:7];

  initial begin
    for (int i = 0; i < 8; i++) mem[i] = 8'hEE;
  end

  // Buffer model: asynchronous read of the presented address, write at edge.
  always_comb begin
    if (address_b_x < 10'd4 && address_b_y < 10'd2)
      data_b = mem[int'(address_b_y) * 4 + int'(address_b_x)];
    else
      data_b = 8'hEE;
  end

  always @(posedge clock) begin
    if (write_enable_b && address_b_x < 10'd4 && address_b_y < 10'd2)
      mem[int'(address_b_y) * 4 + int'(address_b_x)] <= write_data_b;
  end

  frame_swap_controller #(
    .WIDTH(4), .HEIGHT(2), .CLEAR_ON_SWAP(1'b1), .CLEAR_COLOR(8'h00)
  ) u_dut (
    .clock(clock), .reset(reset),
    .req_valid(req_valid), .req_write(req_write), .req_x(req_x), .req_y(req_y),
    .req_data(req_data), .req_ready(req_ready),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data),
    .render_done(render_done), .vblank_start(vblank_start),
    .address_b_x(address_b_x), .address_b_y(address_b_y),
    .write_enable_b(write_enable_b), .write_data_b(write_data_b), .data_b(data_b),
    .frame_complete(frame_complete), .frame_count(frame_count), .busy(busy)
  );

  frame_swap_controller #(
    .WIDTH(4), .HEIGHT(2), .CLEAR_ON_SWAP(1'b0), .CLEAR_COLOR(8'h00)
  ) u_dut_nc (
    .clock(clock), .reset(reset_nc),
    .req_valid(1'b0), .req_write(1'b0), .req_x(10'd0), .req_y(10'd0),
    .req_data(8'h00), .req_ready(req_ready_nc),
    .rsp_valid(rsp_valid_nc), .rsp_data(rsp_data_nc),
    .render_done(render_done_nc), .vblank_start(vblank_start_nc),
    .address_b_x(address_b_x_nc), .address_b_y(address_b_y_nc),
    .write_enable_b(write_enable_b_nc), .write_data_b(write_data_b_nc), .data_b(data_b_nc),
    .frame_complete(frame_complete_nc), .frame_count(frame_count_nc), .busy(busy_nc)
  );

  // Advance one clock; outputs are then stable and inputs apply to this cycle.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick();
    tick();
    checks++;
    if (req_ready !== 1'b0 || busy !== 1'b1 || write_enable_b !== 1'b0 || rsp_valid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_ctrl got ready=%b busy=%b we=%b rv=%b exp 0 1 0 0",
               req_ready, busy, write_enable_b, rsp_valid);
    end
    checks++;
    if (address_b_x !== 10'd0 || address_b_y !== 10'd0 || write_data_b !== 8'h00 ||
        rsp_data !== 8'h00 || frame_count !== 16'd0 || frame_complete !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_data got x=%0d y=%0d wd=%h rd=%h fc=%0d fcp=%b exp all 0",
               address_b_x, address_b_y, write_data_b, rsp_data, frame_count, frame_complete);
    end
    reset = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick();
      checks++;
      if (write_enable_b !== 1'b1 || address_b_x !== 10'(i % 4) || address_b_y !== 10'(i / 4) ||
          write_data_b !== 8'h00) begin
        errors++;
        $display("[TB] FAIL reset_clear_%0d got we=%b (%0d,%0d)=%h exp we=1 (%0d,%0d)=00",
                 i, write_enable_b, address_b_x, address_b_y, write_data_b, i % 4, i / 4);
      end
      if (i == 6) begin
        checks++;
        if (req_ready !== 1'b0 || busy !== 1'b1) begin
          errors++;
          $display("[TB] FAIL clear_busy got ready=%b busy=%b exp 0 1", req_ready, busy);
        end
      end
    end
    checks++;
    if (req_ready !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("[TB] FAIL clear_done got ready=%b busy=%b exp 1 0", req_ready, busy);
    end
  endtask

  task automatic test_write_read();
    req_valid = 1'b1; req_write = 1'b1; req_x = 10'd2; req_y = 10'd1; req_data = 8'hA5;
    tick();
    checks++;
    if (write_enable_b !== 1'b1 || address_b_x !== 10'd2 || address_b_y !== 10'd1 ||
        write_data_b !== 8'hA5) begin
      errors++;
      $display("[TB] FAIL wr_port got we=%b (%0d,%0d)=%h exp we=1 (2,1)=a5",
               write_enable_b, address_b_x, address_b_y, write_data_b);
    end
    req_valid = 1'b0; req_write = 1'b0;
    tick();
    checks++;
    if (write_enable_b !== 1'b0) begin
      errors++;
      $display("[TB] FAIL wr_one_cycle got we=%b exp 0", write_enable_b);
    end
    req_valid = 1'b1; req_write = 1'b0; req_x = 10'd2; req_y = 10'd1;
    tick();
    req_valid = 1'b0;
    checks++;
    if (rsp_valid !== 1'b0 || write_enable_b !== 1'b0) begin
      errors++;
      $display("[TB] FAIL rd_early got rv=%b we=%b exp 0 0", rsp_valid, write_enable_b);
    end
    tick();
    checks++;
    if (rsp_valid !== 1'b1 || rsp_data !== 8'hA5) begin
      errors++;
      $display("[TB] FAIL rd_rsp got rv=%b data=%h exp 1 a5", rsp_valid, rsp_data);
    end
    tick();
    checks++;
    if (rsp_valid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL rd_pulse got rv=%b exp 0", rsp_valid);
    end
  endtask

  task automatic test_back_to_back();
    req_valid = 1'b1; req_write = 1'b1; req_x = 10'd0; req_y = 10'd0; req_data = 8'h11;
    tick();
    checks++;
    if (write_enable_b !== 1'b1 || address_b_x !== 10'd0 || write_data_b !== 8'h11) begin
      errors++;
      $display("[TB] FAIL b2b_wr0 got we=%b x=%0d wd=%h exp 1 0 11", write_enable_b, address_b_x, write_data_b);
    end
    req_x = 10'd1; req_data = 8'h22;
    tick();
    checks++;
    if (write_enable_b !== 1'b1 || address_b_x !== 10'd1 || write_data_b !== 8'h22) begin
      errors++;
      $display("[TB] FAIL b2b_wr1 got we=%b x=%0d wd=%h exp 1 1 22", write_enable_b, address_b_x, write_data_b);
    end
    req_write = 1'b0; req_x = 10'd0;
    tick();
    req_x = 10'd1;
    tick();
    req_valid = 1'b0;
    checks++;
    if (rsp_valid !== 1'b1 || rsp_data !== 8'h11) begin
      errors++;
      $display("[TB] FAIL b2b_rsp0 got rv=%b data=%h exp 1 11", rsp_valid, rsp_data);
    end
    tick();
    checks++;
    if (rsp_valid !== 1'b1 || rsp_data !== 8'h22) begin
      errors++;
      $display("[TB] FAIL b2b_rsp1 got rv=%b data=%h exp 1 22", rsp_valid, rsp_data);
    end
    tick();
  endtask

  task automatic test_out_of_range();
    req_valid = 1'b1; req_write = 1'b1; req_x = 10'd5; req_y = 10'd0; req_data = 8'h77;
    tick();
    checks++;
    if (write_enable_b !== 1'b0) begin
      errors++;
      $display("[TB] FAIL oor_wr got we=%b exp 0", write_enable_b);
    end
    req_write = 1'b0; req_x = 10'd0; req_y = 10'd3;
    tick();
    req_valid = 1'b0;
    checks++;
    if (write_enable_b !== 1'b0 || rsp_valid !== 1'b0 || address_b_x !== 10'd1 || address_b_y !== 10'd0) begin
      errors++;
      $display("[TB] FAIL oor_hold got we=%b rv=%b (%0d,%0d) exp 0 0 (1,0)",
               write_enable_b, rsp_valid, address_b_x, address_b_y);
    end
    tick();
    checks++;
    if (rsp_valid !== 1'b1 || rsp_data !== 8'h00) begin
      errors++;
      $display("[TB] FAIL oor_rd got rv=%b data=%h exp 1 00", rsp_valid, rsp_data);
    end
  endtask

  task automatic test_swap_gating();
    int pulses;
    pulses = 0;
    vblank_start = 1'b1;
    tick();
    vblank_start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (frame_complete === 1'b1) pulses++;
    end
    checks++;
    if (req_ready !== 1'b1 || frame_count !== 16'd0) begin
      errors++;
      $display("[TB] FAIL stray_vblank got ready=%b fc=%0d exp 1 0", req_ready, frame_count);
    end
    render_done = 1'b1;
    tick();
    render_done = 1'b0;
    checks++;
    if (req_ready !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("[TB] FAIL wait_vsync got ready=%b busy=%b exp 0 1", req_ready, busy);
    end
    for (int i = 0; i < 9; i++) begin
      render_done = (i == 3);
      tick();
      if (frame_complete === 1'b1) pulses++;
    end
    render_done = 1'b0;
    vblank_start = 1'b1;
    tick();
    vblank_start = 1'b0;
    checks++;
    if (frame_complete !== 1'b1 || frame_count !== 16'd1 || busy !== 1'b1 || write_enable_b !== 1'b0) begin
      errors++;
      $display("[TB] FAIL swap_strobe got fcp=%b fc=%0d busy=%b we=%b exp 1 1 1 0",
               frame_complete, frame_count, busy, write_enable_b);
    end
    for (int i = 0; i < 8; i++) begin
      tick();
      if (frame_complete === 1'b1) pulses++;
      checks++;
      if (write_enable_b !== 1'b1 || address_b_x !== 10'(i % 4) || address_b_y !== 10'(i / 4) ||
          write_data_b !== 8'h00) begin
        errors++;
        $display("[TB] FAIL swap_clear_%0d got we=%b (%0d,%0d)=%h exp we=1 (%0d,%0d)=00",
                 i, write_enable_b, address_b_x, address_b_y, write_data_b, i % 4, i / 4);
      end
    end
    checks++;
    if (pulses != 0 || req_ready !== 1'b1 || frame_count !== 16'd1) begin
      errors++;
      $display("[TB] FAIL swap_once got extra=%0d ready=%b fc=%0d exp 0 1 1", pulses, req_ready, frame_count);
    end
  endtask

  task automatic test_reset_mid_clear();
    render_done = 1'b1;
    tick();
    render_done = 1'b0;
    vblank_start = 1'b1;
    tick();
    vblank_start = 1'b0;
    tick();
    tick();
    tick();
    checks++;
    if (frame_count !== 16'd2 || write_enable_b !== 1'b1 || address_b_x !== 10'd2) begin
      errors++;
      $display("[TB] FAIL mid_clear got fc=%0d we=%b x=%0d exp 2 1 2", frame_count, write_enable_b, address_b_x);
    end
    reset = 1'b1;
    #1;
    checks++;
    if (write_enable_b !== 1'b0 || frame_count !== 16'd0 || address_b_x !== 10'd0 || frame_complete !== 1'b0) begin
      errors++;
      $display("[TB] FAIL async_reset got we=%b fc=%0d x=%0d fcp=%b exp 0 0 0 0",
               write_enable_b, frame_count, address_b_x, frame_complete);
    end
    tick();
    reset = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick();
      checks++;
      if (write_enable_b !== 1'b1 || address_b_x !== 10'(i % 4) || address_b_y !== 10'(i / 4) ||
          frame_count !== 16'd0 || frame_complete !== 1'b0) begin
        errors++;
        $display("[TB] FAIL restart_clear_%0d got we=%b (%0d,%0d) fc=%0d fcp=%b exp we=1 (%0d,%0d) 0 0",
                 i, write_enable_b, address_b_x, address_b_y, frame_count, frame_complete, i % 4, i / 4);
      end
    end
  endtask

  task automatic test_no_clear_on_swap();
    int writes;
    writes = 0;
    reset_nc = 1'b1;
    tick();
    checks++;
    if (req_ready_nc !== 1'b1 || busy_nc !== 1'b0 || rsp_valid_nc !== 1'b0) begin
      errors++;
      $display("[TB] FAIL nc_reset got ready=%b busy=%b rv=%b exp 1 0 0", req_ready_nc, busy_nc, rsp_valid_nc);
    end
    reset_nc = 1'b0;
    tick();
    render_done_nc = 1'b1;
    tick();
    render_done_nc = 1'b0;
    vblank_start_nc = 1'b1;
    tick();
    vblank_start_nc = 1'b0;
    checks++;
    if (frame_complete_nc !== 1'b1 || frame_count_nc !== 16'd1 || req_ready_nc !== 1'b0) begin
      errors++;
      $display("[TB] FAIL nc_swap got fcp=%b fc=%0d ready=%b exp 1 1 0",
               frame_complete_nc, frame_count_nc, req_ready_nc);
    end
    tick();
    checks++;
    if (req_ready_nc !== 1'b1 || busy_nc !== 1'b0 || frame_complete_nc !== 1'b0) begin
      errors++;
      $display("[TB] FAIL nc_render got ready=%b busy=%b fcp=%b exp 1 0 0",
               req_ready_nc, busy_nc, frame_complete_nc);
    end
    if (write_enable_b_nc === 1'b1) writes++;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (write_enable_b_nc === 1'b1) writes++;
    end
    checks++;
    if (writes != 0) begin
      errors++;
      $display("[TB] FAIL nc_no_clear got writes=%0d exp 0", writes);
    end
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_back_to_back();
    test_out_of_range();
    test_swap_gating();
    test_reset_mid_clear();
    test_no_clear_on_swap();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog got timeout exp completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
